// File: rtl/wb_reset_seq_if.sv
// Control/status bundle between the wb_host reset sequencer and its surroundings.
interface wb_reset_seq_if #(
    parameter int NUM_DOM = 4
);
    logic               cfg_fast_sim;
    logic               soft_boot_req;
    logic [NUM_DOM-1:0] cfg_reboot_mask;
    logic [NUM_DOM-1:0] rst_n;
    logic [NUM_DOM-1:0] clk_enb;
    logic               force_refclk;
    logic               soft_reboot;
    logic               seq_done;
    logic [7:0]         reboot_cnt;

    modport master (
        output cfg_fast_sim, soft_boot_req, cfg_reboot_mask,
        input  rst_n, clk_enb, force_refclk, soft_reboot, seq_done, reboot_cnt
    );

    modport slave (
        input  cfg_fast_sim, soft_boot_req, cfg_reboot_mask,
        output rst_n, clk_enb, force_refclk, soft_reboot, seq_done, reboot_cnt
    );
endinterface

// File: rtl/wb_reset_seq.sv
// Multi-domain reset/clock-enable sequencer: ascending power-on release, masked descending soft reboot.
// Reboot requests act two edges after capture; WB_RST_REBOOT_CNT_EN adds a saturating reboot counter.
module wb_reset_seq #(
    parameter int NUM_DOM        = 4,
    parameter int CNT_W          = 16,
    parameter int PWRUP_CYC      = 60000,
    parameter int FAST_PWRUP_CYC = 100,
    parameter int STEP_CYC       = 16
) (
    input  logic          clk,
    input  logic          e_reset,
    wb_reset_seq_if.slave bus
);
    localparam int                IDX_W      = $clog2(NUM_DOM);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_DOM - 1);
    localparam logic [CNT_W-1:0]  STEP_LAST  = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0]  PWRUP_LAST = CNT_W'(PWRUP_CYC);
    localparam logic [CNT_W-1:0]  FAST_LAST  = CNT_W'(FAST_PWRUP_CYC);

    typedef enum logic [2:0] {
        ST_PWR_UP,
        ST_CLK_ON,
        ST_REL0,
        ST_FORCE_OFF,
        ST_REL_REST,
        ST_RUN,
        ST_ASSERT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [NUM_DOM-1:0] mask;
    logic [NUM_DOM-1:0] rst_n_q;
    logic [NUM_DOM-1:0] clk_enb_q;
    logic               force_q;
    logic               soft_q;
    logic               done_q;
    logic               req_meta;
    logic               req_ss;
    logic               req_d;

    logic [CNT_W-1:0]   exit_cnt;
    logic               tick;
    logic               req_rise;
    logic [NUM_DOM-1:0] mask_in;
    logic               accept;

    // Domain 0 is never part of a reboot, so its mask bit is dropped at the input.
    always_comb begin
        mask_in    = bus.cfg_reboot_mask;
        mask_in[0] = 1'b0;
    end

    assign exit_cnt = bus.cfg_fast_sim ? FAST_LAST : PWRUP_LAST;
    assign tick     = (state == ST_PWR_UP) ? (cnt == exit_cnt) : (cnt == STEP_LAST);
    assign req_rise = req_ss & ~req_d;
    assign accept   = (state == ST_RUN) && req_rise && (mask_in != '0);

    always_ff @(posedge clk or posedge e_reset) begin
        if (e_reset) begin
            state     <= ST_PWR_UP;
            cnt       <= '0;
            idx       <= '0;
            mask      <= '0;
            rst_n_q   <= '0;
            clk_enb_q <= '0;
            force_q   <= 1'b1;
            soft_q    <= 1'b0;
            done_q    <= 1'b0;
            req_meta  <= 1'b0;
            req_ss    <= 1'b0;
            req_d     <= 1'b0;
        end else begin
            req_meta <= bus.soft_boot_req;
            req_ss   <= req_meta;
            req_d    <= req_ss;

            if (state != ST_RUN) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end

            case (state)
                ST_PWR_UP: begin
                    if (tick) state <= ST_CLK_ON;
                end
                // soft_q doubles as the boot/reboot selector: only e_reset clears it.
                ST_CLK_ON: begin
                    if (tick) begin
                        if (soft_q) begin
                            clk_enb_q <= clk_enb_q | mask;
                            state     <= ST_FORCE_OFF;
                        end else begin
                            clk_enb_q <= '1;
                            state     <= ST_REL0;
                        end
                    end
                end
                ST_REL0: begin
                    if (tick) begin
                        rst_n_q[0] <= 1'b1;
                        state      <= ST_FORCE_OFF;
                    end
                end
                ST_FORCE_OFF: begin
                    if (tick) begin
                        force_q <= 1'b0;
                        idx     <= IDX_W'(1);
                        state   <= ST_REL_REST;
                    end
                end
                ST_REL_REST: begin
                    if (tick) begin
                        if (!soft_q || mask[idx]) rst_n_q[idx] <= 1'b1;
                        if (idx == LAST_IDX) begin
                            done_q <= 1'b1;
                            state  <= ST_RUN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        mask      <= mask_in;
                        soft_q    <= 1'b1;
                        force_q   <= 1'b1;
                        done_q    <= 1'b0;
                        clk_enb_q <= clk_enb_q & ~mask_in;
                        cnt       <= '0;
                        idx       <= LAST_IDX;
                        state     <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (tick) begin
                        if (mask[idx]) rst_n_q[idx] <= 1'b0;
                        if (idx == IDX_W'(1)) state <= ST_CLK_ON;
                        else                  idx   <= idx - 1'b1;
                    end
                end
                default: state <= ST_PWR_UP;
            endcase
        end
    end

    assign bus.rst_n        = rst_n_q;
    assign bus.clk_enb      = clk_enb_q;
    assign bus.force_refclk = force_q;
    assign bus.soft_reboot  = soft_q;
    assign bus.seq_done     = done_q;

`ifdef WB_RST_REBOOT_CNT_EN
    logic [7:0] reboot_cnt_q;

    always_ff @(posedge clk or posedge e_reset) begin
        if (e_reset) begin
            reboot_cnt_q <= '0;
        end else if (accept && reboot_cnt_q != 8'hFF) begin
            reboot_cnt_q <= reboot_cnt_q + 8'd1;
        end
    end

    assign bus.reboot_cnt = reboot_cnt_q;
`else
    assign bus.reboot_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_wb_reset_seq.sv
// Randomized bench for wb_reset_seq: boot timeline, masked reboots, dropped requests, reset abort, slow power-up.
module tb_wb_reset_seq;
    localparam int N    = 4;
    localparam int STEP = 16;
    localparam int FAST = 100;
    localparam int SLOW = 60000;

    logic clk      = 1'b0;
    logic e_reset  = 1'b1;
    logic e_reset2 = 1'b1;

    int errors      = 0;
    int checks      = 0;
    bit exp_soft    = 1'b0;
    int exp_reboots = 0;

    wb_reset_seq_if #(.NUM_DOM(N)) bus ();
    wb_reset_seq_if #(.NUM_DOM(2)) bus2 ();

    wb_reset_seq #(
        .NUM_DOM(N), .CNT_W(16), .PWRUP_CYC(SLOW), .FAST_PWRUP_CYC(FAST), .STEP_CYC(STEP)
    ) dut (
        .clk(clk), .e_reset(e_reset), .bus(bus)
    );

    wb_reset_seq #(
        .NUM_DOM(2), .CNT_W(16), .PWRUP_CYC(SLOW), .FAST_PWRUP_CYC(FAST), .STEP_CYC(STEP)
    ) dut2 (
        .clk(clk), .e_reset(e_reset2), .bus(bus2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_rcnt();
`ifdef WB_RST_REBOOT_CNT_EN
        return (exp_reboots > 255) ? 8'hFF : 8'(exp_reboots);
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [2*N+10:0] snap();
        return {bus.rst_n, bus.clk_enb, bus.force_refclk, bus.soft_reboot, bus.seq_done, bus.reboot_cnt};
    endfunction

    task automatic test_reset();
        logic [2*N+10:0] e;
        repeat (3) step();
        e = {{N{1'b0}}, {N{1'b0}}, 1'b1, 1'b0, 1'b0, 8'h00};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", snap(), e);
        end
        checks++;
        if ({bus2.rst_n, bus2.clk_enb, bus2.force_refclk, bus2.seq_done} !== 6'b0000_1_0) begin
            errors++;
            $display("FAIL reset_state_dut2: got %b want 000010",
                     {bus2.rst_n, bus2.clk_enb, bus2.force_refclk, bus2.seq_done});
        end
    endtask

    // Expects e_reset high on entry; edge 1 is the first edge after release.
    task automatic test_boot(input string tag);
        int p, last;
        logic [N-1:0] er, ec;
        logic ef, ed;
        logic [2*N+10:0] e, o;
        p    = FAST + 1;
        last = p + 3*STEP + STEP*(N-1);
        step();
        e_reset = 1'b0;
        for (int n = 1; n <= last + 4; n++) begin
            step();
            ec    = (n >= p + STEP) ? '1 : '0;
            er    = '0;
            er[0] = (n >= p + 2*STEP);
            for (int d = 1; d < N; d++) er[d] = (n >= p + 3*STEP + STEP*d);
            ef = (n < p + 3*STEP);
            ed = (n >= last);
            e  = {er, ec, ef, exp_soft, ed, exp_rcnt()};
            o  = snap();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s edge %0d: got %h want %h", tag, n, o, e);
            end
        end
    endtask

    // hold_at >= 0 raises a second request at that cycle and keeps it high past the return to RUN.
    task automatic test_reboot(input logic [N-1:0] mask_req, input int hold_at, input string tag);
        logic [N-1:0] m, er, ec;
        logic ef, ed;
        logic [2*N+10:0] e, o;
        int width, t, tend;
        m    = mask_req;
        m[0] = 1'b0;
        bus.cfg_reboot_mask = mask_req;
        repeat ($urandom_range(0, 5)) step();
        width = $urandom_range(1, 3);
        tend  = 2*N*STEP + 40;
        bus.soft_boot_req = 1'b1;
        for (int i = 0; i <= tend + 2; i++) begin
            step();
            t = i - 2;
            if (t == 0) begin
                exp_soft = 1'b1;
                exp_reboots++;
            end
            if (t < 0) begin
                e = {{N{1'b1}}, {N{1'b1}}, 1'b0, exp_soft, 1'b1, exp_rcnt()};
            end else begin
                er = '1;
                ec = '1;
                for (int d = 1; d < N; d++) begin
                    if (m[d] && t >= STEP*(N-d) && t < STEP*(N+1+d)) er[d] = 1'b0;
                    if (m[d] && t < STEP*N) ec[d] = 1'b0;
                end
                ef = (t < STEP*(N+1));
                ed = (t >= 2*N*STEP);
                e  = {er, ec, ef, 1'b1, ed, exp_rcnt()};
            end
            o = snap();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s t=%0d mask=%b: got %h want %h", tag, t, mask_req, o, e);
            end
            if (i == width - 1) bus.soft_boot_req = 1'b0;
            if (hold_at >= 0 && i == hold_at) bus.soft_boot_req = 1'b1;
        end
        bus.soft_boot_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_ignored();
        logic [2*N+10:0] e;
        bus.cfg_reboot_mask = N'($urandom_range(0, 1));
        bus.soft_boot_req   = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            e = {{N{1'b1}}, {N{1'b1}}, 1'b0, exp_soft, 1'b1, exp_rcnt()};
            checks++;
            if (snap() !== e) begin
                errors++;
                $display("FAIL ignored_mask cyc %0d: got %h want %h", i, snap(), e);
            end
            if (i == 2) bus.soft_boot_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [2*N+10:0] e;
        bus.cfg_reboot_mask = N'($urandom_range(2, (1 << N) - 1));
        bus.soft_boot_req   = 1'b1;
        step();
        bus.soft_boot_req = 1'b0;
        repeat (2 + $urandom_range(1, STEP*(N-1) - 1)) step();
        #2 e_reset = 1'b1;
        #1;
        exp_soft    = 1'b0;
        exp_reboots = 0;
        e = {{N{1'b0}}, {N{1'b0}}, 1'b1, 1'b0, 1'b0, 8'h00};
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL reset_mid_async: got %h want %h", snap(), e);
        end
        repeat (3) step();
        test_boot("boot_after_abort");
    endtask

    task automatic test_reboot_cnt();
        logic [7:0] want;
`ifdef WB_RST_REBOOT_CNT_EN
        want = 8'd3;
`else
        want = 8'd0;
`endif
        checks++;
        if (bus.reboot_cnt !== want) begin
            errors++;
            $display("FAIL reboot_cnt: got %0d want %0d", bus.reboot_cnt, want);
        end
    endtask

    task automatic test_normal_powerup();
        step();
        e_reset2 = 1'b0;
        for (int n = 1; n <= SLOW + 66; n++) begin
            step();
            if (n == SLOW + 16 || n == SLOW + 17) begin
                checks++;
                if (bus2.clk_enb !== ((n == SLOW + 17) ? 2'b11 : 2'b00)) begin
                    errors++;
                    $display("FAIL slow_clk_enb edge %0d: got %b", n, bus2.clk_enb);
                end
            end
            if (n == SLOW + 64 || n == SLOW + 65) begin
                checks++;
                if ({bus2.rst_n[1], bus2.seq_done} !== ((n == SLOW + 65) ? 2'b11 : 2'b00)) begin
                    errors++;
                    $display("FAIL slow_rst_n1 edge %0d: got %b", n, {bus2.rst_n[1], bus2.seq_done});
                end
            end
        end
    endtask

    initial begin
        bus.cfg_fast_sim     = 1'b1;
        bus.soft_boot_req    = 1'b0;
        bus.cfg_reboot_mask  = '0;
        bus2.cfg_fast_sim    = 1'b0;
        bus2.soft_boot_req   = 1'b0;
        bus2.cfg_reboot_mask = '0;

        test_reset();
        test_boot("boot");
        test_reboot(N'(4'b0110), -1, "reboot_0110");
        test_ignored();
        test_reboot(N'($urandom_range(2, (1 << N) - 1)), $urandom_range(6, STEP*(N-1) - 4), "back_to_back");
        test_reset_mid();
        for (int r = 0; r < 3; r++) begin
            test_reboot(N'($urandom_range(2, (1 << N) - 1)), -1, "reboot_rand");
        end
        test_reboot_cnt();
        test_normal_powerup();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
